// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: owns the register-file write port, runs clear sweeps and arbitrates ALU/MEM writebacks
module regfile_write_scheduler #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              init_start,
  output logic              init_busy,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegNo,
  output logic [DATA_W-1:0] WriteData
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end
  if (NUM_REGS != 2 ** ADDR_W) begin : g_bad_regs
    $error("NUM_REGS must equal 2**ADDR_W");
  end
  typedef enum logic {CLEAR, RUN} state_t;
  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [3:0]          starve_q;
  logic [3:0]          starve_d;
  logic                we_q;
  logic [ADDR_W-1:0]   wn_q;
  logic [DATA_W-1:0]   wd_q;
  logic                run_grant;
  logic                alu_force;
  logic                accept;
  logic                do_write;
  logic [ADDR_W-1:0]   acc_reg;
  logic [DATA_W-1:0]   acc_data;
  assign alu_force  = starve_q == 4'(STARVE_LIMIT);
  assign run_grant  = state_q == RUN && !init_start;
  assign mem_ready  = run_grant & mem_valid & !alu_force;
  assign alu_ready  = run_grant & alu_valid & (!mem_valid | alu_force);
  assign init_busy  = state_q == CLEAR;
  assign accept     = alu_ready | mem_ready;
  assign acc_reg    = alu_ready ? alu_reg : mem_reg;
  assign acc_data   = alu_ready ? alu_data : mem_data;
  assign do_write   = accept && acc_reg != '0;
  assign RegWrite   = we_q;
  assign WriteRegNo = wn_q;
  assign WriteData  = wd_q;
  // starvation counter: cleared on ALU accept, saturating count of stalled ALU cycles
  always_comb begin
    starve_d = starve_q;
    if (alu_ready) starve_d = '0;
    else if (alu_valid && !alu_force) starve_d = starve_q + 4'd1;
  end
  // sweep/run sequencing with registered write-port outputs
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      wn_q     <= '0;
      wd_q     <= '0;
    end else if (state_q == CLEAR) begin
      we_q     <= 1'b1;
      wn_q     <= ptr_q;
      wd_q     <= '0;
      ptr_q    <= ptr_q + 1'b1;
      starve_q <= '0;
      if (ptr_q == ADDR_W'(NUM_REGS - 1)) state_q <= RUN;
    end else if (init_start) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
    end else begin
      we_q     <= do_write;
      starve_q <= starve_d;
      if (do_write) begin
        wn_q <= acc_reg;
        wd_q <= acc_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: directed checks of sweep, arbitration, reg-0 discard and reset restart
module tb_regfile_write_scheduler;
  logic        Clock = 1'b0;
  logic        Reset;
  logic        alu_valid, mem_valid, init_start;
  logic        alu_ready, mem_ready, init_busy;
  logic [4:0]  alu_reg, mem_reg;
  logic [31:0] alu_data, mem_data;
  logic        RegWrite;
  logic [4:0]  WriteRegNo;
  logic [31:0] WriteData;
  int total = 0;
  int passed = 0;
  int fails = 0;

  regfile_write_scheduler #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .init_start(init_start), .init_busy(init_busy),
    .RegWrite(RegWrite), .WriteRegNo(WriteRegNo), .WriteData(WriteData)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < 32; k++) begin
      chk({tag, "_busy"}, 32'(init_busy), 32'd1);
      chk({tag, "_rdy"}, 32'({alu_ready, mem_ready}), 32'd0);
      tick();
      chk({tag, "_we"}, 32'(RegWrite), 32'd1);
      chk({tag, "_wn"}, 32'(WriteRegNo), 32'(k));
      chk({tag, "_wd"}, WriteData, 32'd0);
    end
    chk({tag, "_done"}, 32'(init_busy), 32'd0);
  endtask

  initial begin
    Reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; init_start = 1'b0;
    alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_we", 32'(RegWrite), 32'd0);
    chk("rst_wn", 32'(WriteRegNo), 32'd0);
    chk("rst_wd", WriteData, 32'd0);
    chk("rst_rdy", 32'({alu_ready, mem_ready}), 32'd0);
    Reset = 1'b1;
    sweep("t1");
    tick();
    chk("t1_idle_we", 32'(RegWrite), 32'd0);
    // single ALU write
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    chk("t2_ardy", 32'(alu_ready), 32'd1);
    chk("t2_mrdy", 32'(mem_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    chk("t2_we", 32'(RegWrite), 32'd1);
    chk("t2_wn", 32'(WriteRegNo), 32'd5);
    chk("t2_wd", WriteData, 32'hDEADBEEF);
    tick();
    chk("t2_we_off", 32'(RegWrite), 32'd0);
    chk("t2_wn_hold", 32'(WriteRegNo), 32'd5);
    chk("t2_wd_hold", WriteData, 32'hDEADBEEF);
    // contention: MEM x4 then ALU, repeating
    alu_valid = 1'b1; alu_reg = 5'd7; mem_valid = 1'b1; mem_reg = 5'd9;
    for (int i = 0; i < 10; i++) begin
      alu_data = 32'hA000 + 32'(i);
      mem_data = 32'hB000 + 32'(i);
      #1;
      chk("t3_ardy", 32'(alu_ready), 32'((i % 5) == 4));
      chk("t3_mrdy", 32'(mem_ready), 32'((i % 5) != 4));
      tick();
      chk("t3_we", 32'(RegWrite), 32'd1);
      chk("t3_wn", 32'(WriteRegNo), (i % 5) == 4 ? 32'd7 : 32'd9);
      chk("t3_wd", WriteData, (i % 5) == 4 ? 32'hA000 + 32'(i) : 32'hB000 + 32'(i));
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    // register 0 write is accepted but discarded
    mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'h1234;
    #1;
    chk("t4_mrdy", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    chk("t4_we", 32'(RegWrite), 32'd0);
    chk("t4_wn", 32'(WriteRegNo), 32'd7);
    chk("t4_wd", WriteData, 32'hA009);
    // init_start during traffic
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h3333;
    mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'hCAFE;
    init_start = 1'b1;
    #1;
    chk("t5_ardy", 32'(alu_ready), 32'd0);
    chk("t5_mrdy", 32'(mem_ready), 32'd0);
    tick();
    init_start = 1'b0;
    chk("t5_we", 32'(RegWrite), 32'd0);
    sweep("t5");
    chk("t5_resume_mrdy", 32'(mem_ready), 32'd1);
    chk("t5_resume_ardy", 32'(alu_ready), 32'd0);
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("t5_resume_wn", 32'(WriteRegNo), 32'd9);
    chk("t5_resume_wd", WriteData, 32'hCAFE);
    // reset in the middle of a sweep restarts it from register 0
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (10) tick();
    chk("t6_mid_wn", 32'(WriteRegNo), 32'd9);
    Reset = 1'b0;
    tick();
    chk("t6_rst_we", 32'(RegWrite), 32'd0);
    chk("t6_rst_wn", 32'(WriteRegNo), 32'd0);
    Reset = 1'b1;
    sweep("t6");
    tick();
    chk("t6_idle_we", 32'(RegWrite), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
